// File: rtl/uc_pkg.sv
// Shared types for the multi-mode control unit:
// FSM state encoding and sticky status codes.
package uc_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } estado_t;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_MODO  = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;
    localparam logic [1:0] ERR_ABORT = 2'b11;

endpackage

// File: rtl/detector_borda.sv
// Registered rising-edge detector for the apply button.
// Pulse lasts one cycle; a held level never retriggers.
module detector_borda (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic prev_q;
    logic pulse_q;

    // Track previous level and register the rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= din;
            pulse_q <= din & ~prev_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/uc_multimodo.sv
// Control unit: mode dispatch FSM, watchdog and
// frame-memory arbitration between VGA and the core.
module uc_multimodo
    import uc_pkg::*;
#(
    parameter int                      SRC_AW     = 17,
    parameter int                      DST_AW     = 19,
    parameter int                      DW         = 8,
    parameter int                      MODE_W     = 3,
    parameter logic [2**MODE_W-1:0]    MODE_VALID = 8'h3F,
    parameter int                      TMO_W      = 24,
    parameter logic [TMO_W-1:0]        TMO_MAX    = 24'hFFFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [MODE_W-1:0] chaves,
    input  logic              botao_aplicar,
    input  logic              abortar,
    input  logic              cpu_done,
    output logic              cpu_start,
    output logic [MODE_W-1:0] cpu_modo,
    input  logic [DST_AW-1:0] addr_from_vga_calc,
    input  logic [SRC_AW-1:0] src_addr_from_cpu,
    input  logic [DST_AW-1:0] dest_addr_from_cpu,
    input  logic [DW-1:0]     data_from_cpu,
    input  logic              wren_from_cpu,
    output logic [SRC_AW-1:0] src_mem_addr,
    output logic [DST_AW-1:0] dest_mem_addr,
    output logic [DW-1:0]     dest_mem_data,
    output logic              dest_mem_wren,
    output logic              sistema_ocupado,
    output logic              fim_pulso,
    output logic [1:0]        erro
);

    estado_t           state_q, state_d;
    logic [MODE_W-1:0] modo_q, modo_d;
    logic [1:0]        erro_q, erro_d;
    logic [TMO_W-1:0]  wd_q, wd_d;
    logic              start_q, start_d;
    logic              fim_q, fim_d;
    logic              press;
    logic [TMO_W-1:0]  wd_inc;

    detector_borda u_borda (
        .clk   (clk),
        .reset (reset),
        .din   (botao_aplicar),
        .pulse (press)
    );

    // Saturating watchdog increment; never wraps past TMO_MAX.
    assign wd_inc = (wd_q == TMO_MAX) ? wd_q : wd_q + 1'b1;

    // State, latched mode, status and watchdog registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            modo_q  <= '0;
            erro_q  <= ERR_OK;
            wd_q    <= '0;
            start_q <= 1'b0;
            fim_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            modo_q  <= modo_d;
            erro_q  <= erro_d;
            wd_q    <= wd_d;
            start_q <= start_d;
            fim_q   <= fim_d;
        end
    end

    // Next-state logic; the watchdog is zeroed as START is entered.
    always_comb begin
        state_d = state_q;
        modo_d  = modo_q;
        erro_d  = erro_q;
        wd_d    = wd_q;
        start_d = 1'b0;
        fim_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (press) begin
                    modo_d  = chaves;
                    erro_d  = ERR_OK;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abortar) begin
                    erro_d  = ERR_ABORT;
                    state_d = S_DONE;
                end else if (MODE_VALID[modo_q]) begin
                    wd_d    = '0;
                    start_d = 1'b1;
                    state_d = S_START;
                end else begin
                    erro_d  = ERR_MODO;
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                wd_d = wd_inc;
                if (abortar) begin
                    erro_d  = ERR_ABORT;
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wd_d = wd_inc;
                if (abortar) begin
                    erro_d  = ERR_ABORT;
                    state_d = S_DONE;
                end else if (cpu_done) begin
                    fim_d   = 1'b1;
                    state_d = S_DONE;
                end else if (wd_q == TMO_MAX) begin
                    erro_d  = ERR_TMO;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory mux: core owns memories only while WAITing.
    always_comb begin
        src_mem_addr  = '0;
        dest_mem_addr = addr_from_vga_calc;
        dest_mem_data = '0;
        dest_mem_wren = 1'b0;
        if (state_q == S_WAIT) begin
            src_mem_addr  = src_addr_from_cpu;
            dest_mem_addr = dest_addr_from_cpu;
            dest_mem_data = data_from_cpu;
            dest_mem_wren = wren_from_cpu;
        end
    end

    assign cpu_start       = start_q;
    assign cpu_modo        = modo_q;
    assign fim_pulso       = fim_q;
    assign erro            = erro_q;
    assign sistema_ocupado = (state_q != S_IDLE);

endmodule
